// File: rtl/cbd_sampler.sv
// Centered binomial distribution sampler: turns a 128-bit LSB-first random
// stream into signed coefficients (eta 2 or 3) over a valid/ready output.
module cbd_sampler #(
    parameter int unsigned POLY_LENGTH         = 256,
    parameter int unsigned COEFF_COUNTER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [COEFF_COUNTER_WIDTH-1:0] n_coeffs,
    input  logic [3:0]                     eta,
    input  logic [127:0]                   random_in,
    input  logic                           random_valid,
    output logic                           random_ready,
    input  logic                           coeff_ready,
    output logic                           coeff_valid,
    output logic signed [3:0]              coeff_data,
    output logic                           coeff_last
);

    localparam int unsigned CW     = COEFF_COUNTER_WIDTH;
    localparam int unsigned BUF_W  = 134;
    localparam int unsigned FILL_W = 8;
    localparam int unsigned NEED_W = CW + 3;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic               eta3_q, eta3_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      emitted_q, emitted_d;
    logic [NEED_W-1:0]  words_q, words_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               coeff_valid_q, coeff_valid_d;
    logic signed [3:0]  coeff_data_q, coeff_data_d;
    logic               coeff_last_q, coeff_last_d;

    logic               busy;
    logic [FILL_W-1:0]  chunk;
    logic [FILL_W-1:0]  fill_rem;
    logic [NEED_W-1:0]  bits_needed;
    logic [NEED_W-1:0]  words_needed;
    logic               can_take;
    logic               take_word;
    logic               load;
    logic               last_accept;
    logic [1:0]         pop_a;
    logic [1:0]         pop_b;
    logic signed [3:0]  coeff_new;
    logic [BUF_W-1:0]   buf_shift;
    logic [BUF_W-1:0]   word_ext;

    always_comb begin
        busy  = (state_q == S_BUSY);
        chunk = eta3_q ? FILL_W'(6) : FILL_W'(4);

        // words to request: ceil(count * 2*eta / 128)
        bits_needed  = (NEED_W'(count_q) << 2)
                     + (eta3_q ? (NEED_W'(count_q) << 1) : '0)
                     + NEED_W'(127);
        words_needed = bits_needed >> 7;

        pop_a = {1'b0, buf_q[0]} + {1'b0, buf_q[1]}
              + (eta3_q ? {1'b0, buf_q[2]} : 2'b00);
        pop_b = eta3_q ? ({1'b0, buf_q[3]} + {1'b0, buf_q[4]} + {1'b0, buf_q[5]})
                       : ({1'b0, buf_q[2]} + {1'b0, buf_q[3]});
        coeff_new = $signed({2'b00, pop_a}) - $signed({2'b00, pop_b});

        // ready acts as a request: it drops while a word is on the bus, and the
        // offered word is taken whenever the request conditions still hold.
        can_take     = busy && (fill_q < chunk) && (words_q < words_needed);
        random_ready = can_take && !random_valid;
        take_word    = can_take && random_valid;

        load        = busy && (fill_q >= chunk) && (emitted_q < count_q)
                   && (!coeff_valid_q || coeff_ready);
        last_accept = coeff_valid_q && coeff_ready && coeff_last_q;

        buf_shift = load ? (buf_q >> chunk) : buf_q;
        fill_rem  = load ? (fill_q - chunk) : fill_q;
        word_ext  = {{(BUF_W-128){1'b0}}, random_in};
    end

    always_comb begin
        state_d       = state_q;
        eta3_d        = eta3_q;
        count_d       = count_q;
        emitted_d     = emitted_q;
        words_d       = words_q;
        buf_d         = buf_q;
        fill_d        = fill_q;
        coeff_valid_d = coeff_valid_q;
        coeff_data_d  = coeff_data_q;
        coeff_last_d  = coeff_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    eta3_d    = (eta == 4'd3);
                    count_d   = (n_coeffs > CW'(POLY_LENGTH)) ? CW'(POLY_LENGTH) : n_coeffs;
                    emitted_d = '0;
                    words_d   = '0;
                    buf_d     = '0;
                    fill_d    = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                end

                buf_d   = buf_shift | (take_word ? (word_ext << fill_rem) : '0);
                fill_d  = fill_rem + (take_word ? FILL_W'(128) : '0);
                words_d = words_q + (take_word ? NEED_W'(1) : '0);

                if (load) begin
                    coeff_valid_d = 1'b1;
                    coeff_data_d  = coeff_new;
                    coeff_last_d  = (emitted_q == count_q - CW'(1));
                    emitted_d     = emitted_q + CW'(1);
                end else if (coeff_valid_q && coeff_ready) begin
                    coeff_valid_d = 1'b0;
                    coeff_data_d  = '0;
                    coeff_last_d  = 1'b0;
                end

                if (last_accept) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    fill_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= S_IDLE;
            eta3_q        <= 1'b0;
            count_q       <= '0;
            emitted_q     <= '0;
            words_q       <= '0;
            buf_q         <= '0;
            fill_q        <= '0;
            coeff_valid_q <= 1'b0;
            coeff_data_q  <= '0;
            coeff_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            eta3_q        <= eta3_d;
            count_q       <= count_d;
            emitted_q     <= emitted_d;
            words_q       <= words_d;
            buf_q         <= buf_d;
            fill_q        <= fill_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_data_q  <= coeff_data_d;
            coeff_last_q  <= coeff_last_d;
        end
    end

    assign coeff_valid = coeff_valid_q;
    assign coeff_data  = coeff_data_q;
    assign coeff_last  = coeff_last_q;

endmodule

// File: tb/tb_cbd_sampler.sv
// Directed bench for cbd_sampler: bench-side producer and consumer with
// hand-computed coefficient expectations.
module tb_cbd_sampler;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [15:0]        n_coeffs;
    logic [3:0]         eta;
    logic [127:0]       random_in;
    logic               random_valid;
    logic               random_ready;
    logic               coeff_ready;
    logic               coeff_valid;
    logic signed [3:0]  coeff_data;
    logic               coeff_last;

    cbd_sampler #(.POLY_LENGTH(256), .COEFF_COUNTER_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .n_coeffs     (n_coeffs),
        .eta          (eta),
        .random_in    (random_in),
        .random_valid (random_valid),
        .random_ready (random_ready),
        .coeff_ready  (coeff_ready),
        .coeff_valid  (coeff_valid),
        .coeff_data   (coeff_data),
        .coeff_last   (coeff_last)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] words [0:7];
    int           got [0:299];
    int           got_n;
    int           words_sent;
    int           last_idx;
    int           last_cnt;
    int           run_done;
    int           exp_c [0:63];

    function automatic logic signed [31:0] b2l(input logic b);
        return {31'b0, b};
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic [3:0] e, input logic [15:0] n);
        start    = 1'b1;
        eta      = e;
        n_coeffs = n;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Feeds words on request, collects coefficients, optionally stalls the
    // output for 5 cycles while coefficient 21 is presented.
    task automatic run_stream(input int budget, input bit stall_en);
        int  stall_left;
        bit  stalled;
        got_n = 0; words_sent = 0; last_idx = -1; last_cnt = 0; run_done = 0;
        stall_left = 0; stalled = 0;
        for (int cyc = 0; cyc < budget && run_done == 0; cyc++) begin
            random_valid = 1'b0;
            #1;
            if (random_ready) begin
                random_in    = (words_sent < 8) ? words[words_sent] : '1;
                random_valid = 1'b1;
                words_sent++;
            end
            if (stall_en && !stalled && coeff_valid && got_n == 21) begin
                stall_left = 5;
                stalled    = 1'b1;
            end
            if (stall_left > 0) begin
                coeff_ready = 1'b0;
                check("stall_valid", b2l(coeff_valid), 1);
                check("stall_data", 32'($signed(coeff_data)), 3);
                check("stall_last", b2l(coeff_last), 0);
                stall_left--;
            end else begin
                coeff_ready = 1'b1;
            end
            if (coeff_valid && coeff_ready) begin
                if (got_n < 300) got[got_n] = int'($signed(coeff_data));
                if (coeff_last) begin
                    last_idx = got_n;
                    last_cnt++;
                    run_done = 1;
                end
                got_n++;
            end
            @(posedge clk); #1;
        end
        random_valid = 1'b0;
        coeff_ready  = 1'b0;
        check("run_completed", run_done, 1);
        if (stall_en) check("stall_seen", b2l(stalled), 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("post_ready", b2l(random_ready), 0);
            check("post_valid", b2l(coeff_valid), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int nz;
        int saw;
        rst_n = 1'b1; start = 1'b0; eta = '0; n_coeffs = '0;
        random_in = '0; random_valid = 1'b0; coeff_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", b2l(random_ready), 0);
        check("rst_valid", b2l(coeff_valid), 0);
        check("rst_data", 32'($signed(coeff_data)), 0);
        check("rst_last", b2l(coeff_last), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // eta=2, 64 coefficients from all-ones words: all zero, two words
        for (int i = 0; i < 8; i++) words[i] = '1;
        do_start(4'd2, 16'd64);
        run_stream(400, 1'b0);
        nz = 0;
        for (int i = 0; i < 64; i++) if (got[i] != 0) nz++;
        check("ones_count", got_n, 64);
        check("ones_nonzero", nz, 0);
        check("ones_last_idx", last_idx, 63);
        check("ones_last_cnt", last_cnt, 1);
        check("ones_words", words_sent, 2);

        // zero-length run: nothing emitted, no request
        do_start(4'd2, 16'd0);
        for (int k = 0; k < 3; k++) begin
            check("zero_valid", b2l(coeff_valid), 0);
            check("zero_ready", b2l(random_ready), 0);
            @(posedge clk); #1;
        end

        // eta=2, bits[7:0]=0xC3 -> +2, -2
        words[0] = '0;
        words[0][7:0] = 8'hC3;
        do_start(4'd2, 16'd2);
        run_stream(50, 1'b0);
        check("pm_count", got_n, 2);
        check("pm_c0", got[0], 2);
        check("pm_c1", got[1], -2);
        check("pm_last_idx", last_idx, 1);
        check("pm_words", words_sent, 1);

        // eta=3 straddling: c0=+3, c21=+3 (w0 b126..127 + w1 b0..3),
        // c42=+1 (w1 b124..127 + w2 b0..1), rest 0
        words[0] = '0; words[0][2:0] = 3'b111; words[0][127:126] = 2'b11;
        words[1] = '0; words[1][0] = 1'b1;     words[1][126:124] = 3'b111;
        words[2] = '1;
        for (int i = 0; i < 64; i++) exp_c[i] = 0;
        exp_c[0] = 3; exp_c[21] = 3; exp_c[42] = 1;
        do_start(4'd3, 16'd64);
        run_stream(400, 1'b1);
        check("e3_count", got_n, 64);
        check("e3_words", words_sent, 3);
        check("e3_last_idx", last_idx, 63);
        check("e3_last_cnt", last_cnt, 1);
        for (int i = 0; i < 64; i++) check($sformatf("e3_c%0d", i), got[i], exp_c[i]);

        // n above POLY_LENGTH clamps to 256; eta=5 behaves as eta=2
        for (int i = 0; i < 8; i++) words[i] = '1;
        do_start(4'd5, 16'd300);
        run_stream(1000, 1'b0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (got[i] != 0) nz++;
        check("clamp_count", got_n, 256);
        check("clamp_nonzero", nz, 0);
        check("clamp_last_idx", last_idx, 255);
        check("clamp_words", words_sent, 8);

        // reset mid-run while a coefficient is held
        do_start(4'd2, 16'd64);
        coeff_ready = 1'b0;
        saw = 0;
        for (int cyc = 0; cyc < 10 && saw == 0; cyc++) begin
            random_valid = 1'b0;
            #1;
            if (random_ready) begin
                random_in    = '1;
                random_valid = 1'b1;
            end
            @(posedge clk); #1;
            if (coeff_valid) saw = 1;
        end
        check("mid_valid_seen", saw, 1);
        random_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ready", b2l(random_ready), 0);
        check("mid_rst_valid", b2l(coeff_valid), 0);
        check("mid_rst_data", 32'($signed(coeff_data)), 0);
        check("mid_rst_last", b2l(coeff_last), 0);
        rst_n = 1'b0;
        coeff_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("mid_after_valid", b2l(coeff_valid), 0);
            check("mid_after_ready", b2l(random_ready), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cbd_sampler.md
CBD_SAMPLER -- requirements
Module: cbd_sampler

Interface
REQ-001 SHALL have parameter POLY_LENGTH, default 256: maximum coefficients per run.
REQ-002 SHALL have parameter COEFF_COUNTER_WIDTH, default 16: width of n_coeffs and of the internal coefficient counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: start-of-run pulse.
REQ-006 SHALL have port n_coeffs, input, COEFF_COUNTER_WIDTH bits: number of coefficients to produce; latched on start.
REQ-007 SHALL have port eta, input, 4 bits: CBD parameter; latched on start.
REQ-008 SHALL have port random_in, input, 128 bits: random word, consumed LSB first.
REQ-009 SHALL have port random_valid, input, 1 bit: random_in is valid.
REQ-010 SHALL have port random_ready, output, 1 bit: block can accept a random word.
REQ-011 SHALL have port coeff_ready, input, 1 bit: downstream accepts a coefficient.
REQ-012 SHALL have port coeff_valid, output, 1 bit: coeff_data is valid.
REQ-013 SHALL have port coeff_data, output, signed 4 bits: two's-complement coefficient, range -3..+3.
REQ-014 SHALL have port coeff_last, output, 1 bit: marks the final coefficient of a run.

Function
REQ-015 SHALL implement two states, IDLE and BUSY; on start in IDLE: latch eta, latch n_coeffs, clear the bit buffer, clear counters, go to BUSY.
REQ-016 SHALL use effective eta 3 when the latched eta equals 3, else effective eta 2.
REQ-017 SHALL clamp the effective count to POLY_LENGTH when n_coeffs > POLY_LENGTH.
REQ-018 SHALL, when the effective count is 0, return to IDLE on the next cycle without asserting coeff_valid.
REQ-019 SHALL ignore start while BUSY.
REQ-020 SHALL treat random words as one continuous LSB-first bit stream: bit 0 of word k+1 follows bit 127 of word k.
REQ-021 SHALL let a coefficient straddle word boundaries (for example, eta=3 coefficient 21 uses word0 bits 126-127 and word1 bits 0-3).
REQ-022 SHALL form coefficient i from stream bits [2*eta*i, 2*eta*i + 2*eta): a = popcount of the first eta bits, b = popcount of the next eta bits, coeff_data = a - b.
REQ-023 SHALL hold a bit buffer of at least 133 bits together with a fill count.
REQ-024 SHALL compute random_ready combinationally as: BUSY and !random_valid and fill < 2*eta and words_accepted < ceil(count*2*eta/128).
REQ-025 SHALL accept a word when random_valid && random_ready, appending it above the current fill bits.
REQ-026 SHALL register the coefficient output.
REQ-027 SHALL load a new coefficient when fill >= 2*eta, fewer than count coefficients have been emitted, and either !coeff_valid or coeff_ready; fill then decreases by 2*eta.
REQ-028 SHALL allow a sustained throughput of one coefficient per cycle.
REQ-029 SHALL hold coeff_data, coeff_valid and coeff_last stable while coeff_valid && !coeff_ready.
REQ-030 SHALL deassert coeff_valid when the output slot is consumed and no new coefficient is loaded.
REQ-031 SHALL assert coeff_last only together with coefficient index count-1.
REQ-032 SHALL return to IDLE after the last coefficient is accepted (coeff_valid && coeff_ready && coeff_last) and discard leftover buffered bits.
REQ-033 SHALL allow the same-edge append of an accepted word and removal of 2*eta bits, with fill updated accordingly.

Reset
REQ-034 SHALL, when rst_n=1 at a clock edge, enter IDLE and drive random_ready=0, coeff_valid=0, coeff_data=0, coeff_last=0, clearing the buffer, fill and counters.
REQ-035 SHALL let reset take priority over start and abort any run in progress without further outputs.

Verification
REQ-036 SHALL be verified with: eta=2, n=64, word0 = all ones, word1 = all ones -> 64 coefficients of 0, with coeff_last only on index 63.
REQ-037 SHALL be verified with: eta=2, word0 bits[3:0] = 0x3 then 0xC in bits[7:4] -> coeff0 = +2, coeff1 = -2.
REQ-038 SHALL be verified with: eta=3, word0 bits[5:0] = 0x07, word0 bits 126-127 = 1, word1 bit0 = 1 -> coeff0 = +3, coeff21 = +3.
REQ-039 SHALL be verified with: eta=3, n=64 -> exactly 3 words requested; after the third word random_ready stays 0.
REQ-040 SHALL be verified with: coeff_ready held 0 for 5 cycles mid-run -> coeff_data stable, with no loss or duplication after release.
REQ-041 SHALL be verified with: n_coeffs = 0 -> no coeff_valid, and the block is back in IDLE after 1 cycle; rst_n pulsed mid-run -> all outputs 0 on the next cycle.
